// File: rtl/mult_pipe.sv
// mult_pipe: valid/ready pipelined WIDTHxWIDTH multiplier (signed/unsigned) built from four half-width partial products
module mult_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   c,
    output logic                 busy
);
    localparam int H  = WIDTH / 2;
    localparam int W2 = 2 * WIDTH;
    logic [STAGES-1:0] v;
    logic              stall, take, sgn;
    logic [WIDTH-1:0]  ma, mb, pp_ll, pp_lh, pp_hl, pp_hh;
    logic [W2-1:0]     mag, prod;
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall & ~flush;
    assign take      = in_valid & in_ready;
    assign out_valid = v[STAGES-1];
    assign busy      = |v;
    // negating -2^(WIDTH-1) wraps to itself, which read unsigned is the correct magnitude
    assign ma = (is_signed & a[WIDTH-1]) ? -a : a;
    assign mb = (is_signed & b[WIDTH-1]) ? -b : b;
    assign mag  = {pp_hh, pp_ll} + (W2'(pp_lh) << H) + (W2'(pp_hl) << H);
    assign prod = sgn ? -mag : mag;
    always_ff @(posedge clk) begin
        if (reset) begin
            v     <= '0;
            sgn   <= 1'b0;
            pp_ll <= '0;
            pp_lh <= '0;
            pp_hl <= '0;
            pp_hh <= '0;
        end else if (flush) begin
            v <= '0;
        end else if (!stall) begin
            v <= (v << 1) | STAGES'(take);
            if (take) begin
                sgn   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                pp_ll <= WIDTH'(ma[H-1:0]) * WIDTH'(mb[H-1:0]);
                pp_lh <= WIDTH'(ma[H-1:0]) * WIDTH'(mb[WIDTH-1:H]);
                pp_hl <= WIDTH'(ma[WIDTH-1:H]) * WIDTH'(mb[H-1:0]);
                pp_hh <= WIDTH'(ma[WIDTH-1:H]) * WIDTH'(mb[WIDTH-1:H]);
            end
        end
    end
    generate
        if (STAGES == 1) begin : g_comb
            assign c = prod;
        end else begin : g_reg
            logic [W2-1:0] d [STAGES-1:1];
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 1; i < STAGES; i++) d[i] <= '0;
                end else if (!stall && !flush) begin
                    d[1] <= prod;
                    for (int i = 2; i < STAGES; i++) d[i] <= d[i-1];
                end
            end
            assign c = d[STAGES-1];
        end
    endgenerate
endmodule

// File: tb/tb_mult_pipe.sv
// tb_mult_pipe: scoreboard bench driving STAGES=1,2,4 instances with shared directed and random stimulus
module tb_mult_pipe;
    logic        clk = 0;
    logic        reset = 1, in_valid = 0, is_signed = 0, flush = 0, out_ready = 1;
    logic [31:0] a = 0, b = 0;
    logic        ov [3];
    logic        ir [3];
    logic        bz [3];
    logic [63:0] cc [3];
    int          pend [3];
    int          cyc = 0, checks = 0, fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input int g, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s inst=%0d cyc=%0d got=%h expected=%h", name, g, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint p;
        p = s ? longint'($signed(x)) * longint'($signed(y))
              : longint'({32'b0, x}) * longint'({32'b0, y});
        return 64'(p);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int S = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        logic [63:0] qe [$];
        int          qc [$];
        int          qs [$];
        int          stalls = 0;
        logic        pst = 0, prst = 0;
        logic [63:0] pc = 0;
        mult_pipe #(.WIDTH(32), .STAGES(S)) dut (
            .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[g]),
            .is_signed(is_signed), .a(a), .b(b), .flush(flush),
            .out_valid(ov[g]), .out_ready(out_ready), .c(cc[g]), .busy(bz[g])
        );
        always @(negedge clk) begin
            logic exp_ir;
            exp_ir = !(ov[g] && !out_ready) && !flush;
            if (!reset) begin
                if (prst) begin
                    check(ov[g] == 1'b0, g, "reset_out_valid", 64'(ov[g]), 64'd0);
                    check(bz[g] == 1'b0, g, "reset_busy", 64'(bz[g]), 64'd0);
                    check(cc[g] == 64'd0, g, "reset_c", cc[g], 64'd0);
                end
                if (pst) begin
                    check(ov[g] == 1'b1, g, "stall_valid_hold", 64'(ov[g]), 64'd1);
                    check(cc[g] == pc, g, "stall_c_hold", cc[g], pc);
                end
                check(ir[g] == exp_ir, g, "in_ready", 64'(ir[g]), 64'(exp_ir));
                check(bz[g] == (qe.size() != 0), g, "busy", 64'(bz[g]), 64'(qe.size() != 0));
                if (ov[g] && qe.size() == 0)
                    check(1'b0, g, "spurious_out_valid", 64'(ov[g]), 64'd0);
                if (ov[g] && out_ready && qe.size() != 0) begin
                    logic [63:0] e;
                    int acc, st, lat;
                    e   = qe.pop_front();
                    acc = qc.pop_front();
                    st  = qs.pop_front();
                    lat = cyc - acc - (stalls - st);
                    check(cc[g] == e, g, "product", cc[g], e);
                    check(lat == S, g, "latency", 64'(lat), 64'(S));
                end
                if (flush) begin
                    qe.delete();
                    qc.delete();
                    qs.delete();
                end else begin
                    if (in_valid && exp_ir) begin
                        qe.push_back(model(a, b, is_signed));
                        qc.push_back(cyc);
                        qs.push_back(stalls);
                    end
                    if (ov[g] && !out_ready) stalls++;
                end
            end else begin
                qe.delete();
                qc.delete();
                qs.delete();
            end
            pst     = !reset && !flush && ov[g] && !out_ready;
            pc      = cc[g];
            prst    = reset;
            pend[g] = qe.size();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [31:0] x, input logic [31:0] y, input logic s);
        in_valid = 1; a = x; b = y; is_signed = s;
        step();
        in_valid = 0;
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h1;
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (2) step();
        reset = 0;
        step();
        op(32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        repeat (6) step();
        op(32'h80000000, 32'h80000000, 1);
        repeat (2) step();
        op(32'hFFFFFFFF, 32'h00000003, 1);
        op(32'hFFFFFFFF, 32'h00000003, 0);
        repeat (6) step();
        op(3, 5, 0);
        op(7, 11, 0);
        op(0, 32'h12345678, 0);
        op(1, 32'hFFFFFFFF, 0);
        repeat (6) step();
        for (int i = 0; i < 3; i++) op(100 + i, 3, 0);
        in_valid = 1; out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            a = 200 + i; b = 9;
            step();
        end
        in_valid = 0; out_ready = 1;
        repeat (8) step();
        op(1, 2, 0);
        op(3, 4, 1);
        flush = 1;
        step();
        flush = 0;
        step();
        op(2, 3, 0);
        repeat (6) step();
        op(5, 6, 0);
        op(7, 8, 1);
        reset = 1;
        step();
        reset = 0;
        step();
        op(2, 3, 0);
        repeat (6) step();
        for (int i = 0; i < 2500; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            is_signed = $urandom_range(0, 1);
            a         = rnd_op();
            b         = rnd_op();
            out_ready = ($urandom_range(0, 9) < 8);
            flush     = ($urandom_range(0, 49) == 0);
            reset     = ($urandom_range(0, 99) == 0);
            step();
        end
        in_valid = 0; out_ready = 1; flush = 0; reset = 0;
        repeat (20) step();
        @(negedge clk);
        #1;
        for (int g = 0; g < 3; g++) check(pend[g] == 0, g, "drain_empty", 64'(pend[g]), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
